// File: rtl/multi_clk_divider_pkg.sv
// Shared defaults and types for the multi-channel clock divider.
// Pure declarations: no logic, no latency, no flow control.
package multi_clk_divider_pkg;

  localparam int DIV_W_DEF  = 8;
  localparam int NUM_CH_DEF = 3;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // A ratio of zero parks the channel with all outputs low.
  localparam div_t DIV_DISABLED = '0;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: phase counter, shadow ratio register and registered tick/div_out.
// Outputs change one clk after the inputs; no backpressure; ratio changes land only on a period boundary.
module clk_div_ch
  import multi_clk_divider_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] cfg,
  input  logic             sync,
  output logic             div_out,
  output logic             tick,
  output logic             pend
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] act_div;
  logic [DIV_W-1:0] pend_div;
  logic             pend_v;

  logic [DIV_W-1:0] nxt_pend;
  logic [DIV_W-1:0] new_act;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] half;
  logic             run;
  logic             last;
  logic             commit;

  assign run      = en && (act_div != DIV_W'(DIV_DISABLED));
  assign last     = run && (cnt == act_div - 1'b1);
  assign cnt_inc  = last ? '0 : cnt + 1'b1;
  assign half     = act_div >> 1;

  // A load in the commit cycle wins over the older shadow value.
  assign nxt_pend = load ? cfg : pend_div;
  assign commit   = sync ? (load | pend_v) : (pend_v & (~run | last));
  assign new_act  = commit ? nxt_pend : act_div;

  assign pend     = pend_v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      act_div  <= '0;
      pend_div <= '0;
      pend_v   <= 1'b0;
      div_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      pend_div <= nxt_pend;
      if (sync) begin
        act_div <= new_act;
        cnt     <= '0;
        pend_v  <= 1'b0;
        tick    <= 1'b0;
        div_out <= en && (new_act >= DIV_W'(2));
      end else if (commit) begin
        // At a wrap the old period's tick still fires; the new ratio starts at phase 0.
        act_div <= new_act;
        cnt     <= '0;
        pend_v  <= 1'b0;
        tick    <= run;
        div_out <= run && (new_act >= DIV_W'(2));
      end else if (!run) begin
        cnt     <= '0;
        pend_v  <= load;
        tick    <= 1'b0;
        div_out <= 1'b0;
      end else begin
        cnt     <= cnt_inc;
        pend_v  <= pend_v | load;
        tick    <= last;
        div_out <= (act_div >= DIV_W'(2)) && (cnt_inc < half);
      end
    end
  end

endmodule

// File: rtl/multi_clk_divider.sv
// NUM_CH independent run-time programmable clock dividers sharing one clk, reset and sync.
// Outputs registered, one clk after inputs; no backpressure.
module multi_clk_divider
  import multi_clk_divider_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       div_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pend
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .load   (load[i]),
      .cfg    (div_cfg[i*DIV_W +: DIV_W]),
      .sync   (sync),
      .div_out(div_out[i]),
      .tick   (tick[i]),
      .pend   (pend[i])
    );
  end

endmodule
